pwm_burst_gen: RTL and testbench

- Programmable PWM generator with an optional burst mode.
- Period is given in clock cycles and duty cycle in integer percent.
- In burst mode the output gates whole PWM periods on and off, either repeating or as a single shot.
- Also emits a one-cycle end-of-period strobe that downstream timers use for synchronisation.

---
 rtl/pwm_burst_gen_if.sv | 23 ++
 rtl/pwm_burst_gen.sv | 153 +++++++++++++++
 tb/tb_pwm_burst_gen.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_burst_gen_if.sv
// Bundle of settings and outputs for pwm_burst_gen.
// There is no valid/ready handshake. The settings are level signals that the
// generator samples at a period boundary, or on every cycle while it is idle.
// pwmOut and outRST are registered outputs. dbgState exposes the burst FSM state.
interface pwm_burst_gen_if;
   logic [15:0] period;
   logic [7:0]  dutyCycle;
   logic        modeBurst;
   logic        typeBurst;
   logic        pwmOut;
   logic        outRST;
   logic [1:0]  dbgState;

   modport master (
      output period, dutyCycle, modeBurst, typeBurst,
      input  pwmOut, outRST, dbgState
   );

   modport slave (
      input  period, dutyCycle, modeBurst, typeBurst,
      output pwmOut, outRST, dbgState
   );
endinterface

// File: rtl/pwm_burst_gen.sv
// PWM generator with optional burst gating (repeating or single shot).
// It also produces a one-cycle end-of-period strobe.
// Settings are latched only at period boundaries, so a period is never truncated.
module pwm_burst_gen #(
   parameter int BURST_LEN = 4,
   parameter int BURST_GAP = 4
) (
   input logic           clk,
   input logic           rst,
   pwm_burst_gen_if.slave bus
);
   localparam int CMAX = (BURST_LEN > BURST_GAP) ? BURST_LEN : BURST_GAP;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam logic [CW-1:0] LEN_LAST = CW'(BURST_LEN - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(BURST_GAP - 1);

   // ST_IDLE means not running. ST_ON and ST_GAP are the burst phases.
   // ST_DONE means a single shot has finished.
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ON = 2'd1, ST_GAP = 2'd2, ST_DONE = 2'd3} stateT;

   // Initial values match the reset state, so the block runs correctly without a reset.
   stateT          state    = ST_IDLE;
   logic [15:0]    cnt      = '0;
   logic [15:0]    pLat     = '0;
   logic [23:0]    hLat     = '0;
   logic           modeLat  = 1'b0;
   logic           typeLat  = 1'b0;
   logic [CW-1:0]  burstCnt = '0;
   logic           pwmReg   = 1'b0;
   logic           rstReg   = 1'b0;

   stateT          stateNxt, advState;
   logic [15:0]    cntNxt, pNxt, cntInc;
   logic [23:0]    hNxt, hNow;
   logic           modeNxt, typeNxt, pwmNxt, rstNxt;
   logic [CW-1:0]  bcNxt, advCnt;
   logic [7:0]     dutyClamp;
   logic           lastCycle, modeChange;

   // High time for the currently presented settings: P*min(duty,100)/100, computed 24 bits wide.
   always_comb begin
      dutyClamp = (bus.dutyCycle > 8'd100) ? 8'd100 : bus.dutyCycle;
      hNow      = ({8'd0, bus.period} * {16'd0, dutyClamp}) / 24'd100;
   end

   // Next-state logic: period counter, settings latch, burst phase and output values.
   always_comb begin
      stateNxt   = state;
      cntNxt     = cnt;
      pNxt       = pLat;
      hNxt       = hLat;
      modeNxt    = modeLat;
      typeNxt    = typeLat;
      bcNxt      = burstCnt;
      pwmNxt     = 1'b0;
      rstNxt     = 1'b0;
      cntInc     = cnt + 16'd1;
      lastCycle  = (cnt == pLat - 16'd1);
      modeChange = ({bus.modeBurst, bus.typeBurst} != {modeLat, typeLat});
      advState   = state;
      advCnt     = burstCnt;

      // Advance the burst phase using the mode of the period that is ending.
      if (modeLat) begin
         case (state)
            ST_ON: begin
               if (burstCnt == LEN_LAST) begin
                  advCnt   = '0;
                  advState = typeLat ? ST_DONE : ST_GAP;
               end else begin
                  advCnt = burstCnt + CW'(1);
               end
            end
            ST_GAP: begin
               if (burstCnt == GAP_LAST) begin
                  advCnt   = '0;
                  advState = ST_ON;
               end else begin
                  advCnt = burstCnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
      if (modeChange) begin
         advState = ST_ON;
         advCnt   = '0;
      end

      if (state == ST_IDLE) begin
         // While idle, sample period every cycle until it is nonzero.
         if (bus.period != 16'd0) begin
            pNxt     = bus.period;
            hNxt     = hNow;
            modeNxt  = bus.modeBurst;
            typeNxt  = bus.typeBurst;
            stateNxt = ST_ON;
            bcNxt    = '0;
            cntNxt   = '0;
            pwmNxt   = (hNow != 24'd0);
            rstNxt   = (bus.period == 16'd1);
         end
      end else if (lastCycle) begin
         pNxt    = bus.period;
         hNxt    = hNow;
         modeNxt = bus.modeBurst;
         typeNxt = bus.typeBurst;
         cntNxt  = '0;
         if (bus.period == 16'd0) begin
            stateNxt = ST_IDLE;
            bcNxt    = '0;
         end else begin
            stateNxt = advState;
            bcNxt    = advCnt;
            pwmNxt   = (!bus.modeBurst || advState == ST_ON) && (hNow != 24'd0);
            rstNxt   = (bus.period == 16'd1);
         end
      end else begin
         cntNxt = cntInc;
         pwmNxt = (!modeLat || state == ST_ON) && ({8'd0, cntInc} < hLat);
         rstNxt = (cntInc == pLat - 16'd1);
      end
   end

   // State register with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         pLat     <= '0;
         hLat     <= '0;
         modeLat  <= 1'b0;
         typeLat  <= 1'b0;
         burstCnt <= '0;
         pwmReg   <= 1'b0;
         rstReg   <= 1'b0;
      end else begin
         state    <= stateNxt;
         cnt      <= cntNxt;
         pLat     <= pNxt;
         hLat     <= hNxt;
         modeLat  <= modeNxt;
         typeLat  <= typeNxt;
         burstCnt <= bcNxt;
         pwmReg   <= pwmNxt;
         rstReg   <= rstNxt;
      end
   end

   assign bus.pwmOut   = pwmReg;
   assign bus.outRST   = rstReg;
   assign bus.dbgState = state;
endmodule

// File: tb/tb_pwm_burst_gen.sv
// Bench for pwm_burst_gen: directed test-plan steps followed by randomized segments.
// Each cycle is checked against a period-level reference model.
module tb_pwm_burst_gen;
   localparam int L = 4;
   localparam int G = 4;

   logic clk = 1'b0;
   logic rst;
   pwm_burst_gen_if bus ();

   pwm_burst_gen #(.BURST_LEN(L), .BURST_GAP(G)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Clock: 10 ns period.
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model, in terms of whole periods.
   // mN counts periods since the mode was last latched. mK is the position inside the period.
   bit mRun = 1'b0;
   int mP, mH, mK, mN;
   bit mMode, mType;
   bit expPwm, expRst;

   int   highCycles, pulses, rstPulses;
   logic prevPwm = 1'b0;

   function automatic int calcH(int p, int d);
      int dc;
      dc = (d > 100) ? 100 : d;
      return (p * dc) / 100;
   endfunction

   function automatic bit periodActive(bit md, bit ty, int n);
      if (!md) return 1'b1;
      if (!ty) return (n % (L + G)) < L;
      return n < L;
   endfunction

   task automatic latchModel();
      mP    = int'(bus.period);
      mH    = calcH(int'(bus.period), int'(bus.dutyCycle));
      mMode = bus.modeBurst;
      mType = bus.typeBurst;
   endtask

   task automatic modelStep();
      if (rst) begin
         mRun = 1'b0;
      end else if (!mRun) begin
         if (bus.period != 16'd0) begin
            latchModel();
            mN   = 0;
            mK   = 0;
            mRun = 1'b1;
         end
      end else if (mK == mP - 1) begin
         if ({bus.modeBurst, bus.typeBurst} != {mMode, mType}) mN = 0;
         else mN = mN + 1;
         latchModel();
         mK = 0;
         if (mP == 0) mRun = 1'b0;
      end else begin
         mK = mK + 1;
      end
      expPwm = mRun && periodActive(mMode, mType, mN) && (mK < mH);
      expRst = mRun && (mK == mP - 1);
   endtask

   task automatic checkBit(string tag, logic obs, logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic checkInt(string tag, int obs, int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: step the model at the edge, then compare 1 ns later.
   task automatic tick(string tag);
      @(posedge clk);
      modelStep();
      #1;
      checkBit({tag, "_pwm"}, bus.pwmOut, expPwm);
      checkBit({tag, "_rst"}, bus.outRST, expRst);
      if (bus.pwmOut === 1'b1) highCycles++;
      if (bus.pwmOut === 1'b1 && prevPwm !== 1'b1) pulses++;
      if (bus.outRST === 1'b1) rstPulses++;
      prevPwm = bus.pwmOut;
   endtask

   task automatic runCycles(int n, string tag);
      for (int i = 0; i < n; i++) tick(tag);
   endtask

   task automatic clearCounts();
      highCycles = 0;
      pulses     = 0;
      rstPulses  = 0;
   endtask

   task automatic setCfg(int p, int d, bit md, bit ty);
      bus.period    = 16'(p);
      bus.dutyCycle = 8'(d);
      bus.modeBurst = md;
      bus.typeBurst = ty;
   endtask

   initial begin
      rst = 1'b1;
      setCfg(20, 50, 1'b0, 1'b0);
      clearCounts();
      runCycles(2, "reset");
      rst = 1'b0;

      // Continuous 20/50.
      clearCounts();
      runCycles(60, "cont");
      checkInt("cont_high", highCycles, 30);
      checkInt("cont_strobes", rstPulses, 3);
      checkInt("cont_pulses", pulses, 3);

      // Mid-period change to 10/20. The current period finishes unchanged.
      runCycles(5, "mid_pre");
      setCfg(10, 20, 1'b0, 1'b0);
      clearCounts();
      runCycles(15, "mid_rest");
      checkInt("mid_rest_high", highCycles, 5);
      checkInt("mid_rest_strobe", rstPulses, 1);
      clearCounts();
      runCycles(10, "mid_new");
      checkInt("mid_new_high", highCycles, 2);
      checkInt("mid_new_strobe", rstPulses, 1);

      // Repeating burst.
      setCfg(20, 50, 1'b1, 1'b0);
      for (int b = 0; b < 2; b++) begin
         clearCounts();
         runCycles(160, "rep");
         checkInt("rep_pulses", pulses, 4);
         checkInt("rep_high", highCycles, 40);
         checkInt("rep_strobes", rstPulses, 8);
      end

      // Reset during the second pulse of a burst.
      runCycles(25, "rep_pre_rst");
      rst = 1'b1;
      tick("rst_mid");
      checkBit("rst_mid_pwm0", bus.pwmOut, 1'b0);
      rst = 1'b0;
      clearCounts();
      runCycles(160, "rep_after_rst");
      checkInt("rep_after_rst_pulses", pulses, 4);
      checkInt("rep_after_rst_high", highCycles, 40);

      // Single shot over 5000 ns.
      setCfg(20, 50, 1'b1, 1'b1);
      clearCounts();
      runCycles(500, "single");
      checkInt("single_pulses", pulses, 4);
      checkInt("single_strobes", rstPulses, 25);

      // Duty boundaries in continuous mode.
      setCfg(20, 0, 1'b0, 1'b0);
      clearCounts();
      runCycles(40, "duty0");
      checkInt("duty0_high", highCycles, 0);
      setCfg(20, 100, 1'b0, 1'b0);
      clearCounts();
      runCycles(40, "duty100");
      checkInt("duty100_high", highCycles, 40);
      setCfg(20, 150, 1'b0, 1'b0);
      clearCounts();
      runCycles(40, "duty150");
      checkInt("duty150_high", highCycles, 40);
      setCfg(20, 33, 1'b0, 1'b0);
      clearCounts();
      runCycles(40, "duty33");
      checkInt("duty33_high", highCycles, 12);
      setCfg(0, 50, 1'b0, 1'b0);
      clearCounts();
      runCycles(20, "p0");
      checkInt("p0_high", highCycles, 0);
      checkInt("p0_strobes", rstPulses, 0);

      // Period of 1.
      setCfg(1, 100, 1'b0, 1'b0);
      tick("p1_start");
      clearCounts();
      runCycles(10, "p1_full");
      checkInt("p1_full_high", highCycles, 10);
      checkInt("p1_full_strobes", rstPulses, 10);
      setCfg(1, 50, 1'b0, 1'b0);
      clearCounts();
      runCycles(10, "p1_half");
      checkInt("p1_half_high", highCycles, 0);
      checkInt("p1_half_strobes", rstPulses, 10);

      // Randomized segments, checked cycle by cycle against the model.
      for (int s = 0; s < 40; s++) begin
         setCfg(($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12)),
                int'($urandom_range(0, 160)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 9) == 0) begin
            rst = 1'b1;
            tick("rand_rst");
            rst = 1'b0;
         end
         runCycles(int'($urandom_range(1, 60)), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
